// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register-file write port between the in-order writeback path (A)
//   and a long-latency unit (B). B results queue in a small FIFO; the winning
//   write is registered toward the register file. Pending destinations are
//   reported to decode through q_hit.
//   Optional feature macro: RF_ARB_STARVE_GUARD_EN (forces a B grant after the
//   FIFO head has waited MAX_WAIT cycles).
module regfile_write_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   input  logic [4:0]               a_rd,
   input  logic [31:0]              a_data,
   output logic                     a_ready,
   input  logic                     b_valid,
   input  logic [4:0]               b_rd,
   input  logic [31:0]              b_data,
   output logic                     b_ready,
   input  logic [4:0]               q_rs1,
   input  logic [4:0]               q_rs2,
   output logic                     q_hit,
   output logic                     rf_we,
   output logic [4:0]               rf_rd,
   output logic [31:0]              rf_wd,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]    rd_mem [DEPTH];
   logic [31:0]   wd_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          fifo_nonempty;
   logic          b_push;
   logic          b_store;
   logic          b_pop;
   logic          a_win;
   logic          forced_b;
   logic [AW-1:0] offset;

   assign fifo_nonempty = (count != '0);
   assign b_ready       = (count < DEPTH_C);
   assign b_push        = b_valid && b_ready;
   // An x0 result completes its handshake but never occupies a slot.
   assign b_store       = b_push && (b_rd != 5'd0);
   assign fifo_count    = count;

`ifdef RF_ARB_STARVE_GUARD_EN
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

   // Down-counter of cycles the head may still wait; terminal count forces B.
   logic [WW-1:0] wait_cnt;

   assign forced_b = fifo_nonempty && (wait_cnt == '0);

   // Starvation timer: reload on pop or empty, count down while head is passed over.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= MAX_WAIT_C;
      end else if (b_pop || !fifo_nonempty) begin
         wait_cnt <= MAX_WAIT_C;
      end else if (wait_cnt != '0) begin
         wait_cnt <= wait_cnt - WW'(1);
      end
   end
`else
   logic unused_max_wait;

   assign unused_max_wait = (MAX_WAIT > 0);
   assign forced_b        = 1'b0;
`endif

   // Per-cycle grant: forced B, then A (nonzero rd), then FIFO head.
   always_comb begin
      a_ready = 1'b1;
      a_win   = 1'b0;
      b_pop   = 1'b0;
      if (forced_b) begin
         b_pop   = 1'b1;
         a_ready = 1'b0;
      end else if (a_valid && (a_rd != 5'd0)) begin
         a_win = 1'b1;
      end else if (fifo_nonempty) begin
         b_pop = 1'b1;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (b_store) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (b_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(b_store) - CW'(b_pop);
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every use.
   always_ff @(posedge clk) begin
      if (!rst && b_store) begin
         rd_mem[wr_ptr] <= b_rd;
         wd_mem[wr_ptr] <= b_data;
      end
   end

   // Registered write toward the register file; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we <= 1'b0;
         rf_rd <= 5'd0;
         rf_wd <= 32'd0;
      end else begin
         rf_we <= a_win || b_pop;
         if (a_win) begin
            rf_rd <= a_rd;
            rf_wd <= a_data;
         end else if (b_pop) begin
            rf_rd <= rd_mem[rd_ptr];
            rf_wd <= wd_mem[rd_ptr];
         end
      end
   end

   // Hazard query against every occupied FIFO slot and the output stage.
   always_comb begin
      q_hit  = 1'b0;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = AW'(i) - rd_ptr;
         if (({1'b0, offset} < count) &&
             (((q_rs1 != 5'd0) && (q_rs1 == rd_mem[i])) ||
              ((q_rs2 != 5'd0) && (q_rs2 == rd_mem[i])))) begin
            q_hit = 1'b1;
         end
      end
      if (rf_we &&
          (((q_rs1 != 5'd0) && (q_rs1 == rf_rd)) ||
           ((q_rs2 != 5'd0) && (q_rs2 == rf_rd)))) begin
         q_hit = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (both guard and no-guard builds).
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        b_ready;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        q_hit;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;
   logic [2:0]  fifo_count;

   int total  = 0;
   int passed = 0;

   regfile_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .b_ready    (b_ready),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .q_hit      (q_hit),
      .rf_we      (rf_we),
      .rf_rd      (rf_rd),
      .rf_wd      (rf_wd),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      // 1: reset while B offers a result
      rst = 1'b1; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
      b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33;
      q_rs1 = 5'd3; q_rs2 = 5'd0;
      tick();
      rst = 1'b0; b_valid = 1'b0;
      #1;
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_we", 32'(rf_we), 32'd0);
      check("rst_rd", 32'(rf_rd), 32'd0);
      check("rst_wd", rf_wd, 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd1);
      check("rst_a_ready", 32'(a_ready), 32'd1);
      check("rst_q_hit", 32'(q_hit), 32'd0);

      // 2: single A write, one-cycle latency
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
      #1;
      check("a_ready_a", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0; q_rs1 = 5'd5;
      #1;
      check("a_we", 32'(rf_we), 32'd1);
      check("a_rd", 32'(rf_rd), 32'd5);
      check("a_wd", rf_wd, 32'hDEADBEEF);
      check("a_qhit_outstage", 32'(q_hit), 32'd1);
      tick();
      check("idle_we", 32'(rf_we), 32'd0);
      check("idle_rd_hold", 32'(rf_rd), 32'd5);
      check("idle_qhit", 32'(q_hit), 32'd0);

      // 3: single B write, two-cycle latency
      b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h1234;
      tick();
      b_valid = 1'b0;
      #1;
      check("b1_count", 32'(fifo_count), 32'd1);
      check("b1_we_early", 32'(rf_we), 32'd0);
      tick();
      check("b1_we", 32'(rf_we), 32'd1);
      check("b1_rd", 32'(rf_rd), 32'd9);
      check("b1_wd", rf_wd, 32'h1234);
      check("b1_count_after", 32'(fifo_count), 32'd0);

      // 4: fill FIFO while A writes every cycle
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hAA;
      for (int i = 0; i < 4; i++) begin
         b_valid = 1'b1; b_rd = 5'(10 + i); b_data = 32'(16'hB000 + i);
         tick();
      end
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_b_ready", 32'(b_ready), 32'd0);
      b_rd = 5'd14; b_data = 32'hB004;
      tick();
      b_valid = 1'b0;
      check("full_5th_ignored", 32'(fifo_count), 32'd4);
      check("full_a_we", 32'(rf_we), 32'd1);
      check("full_a_rd", 32'(rf_rd), 32'd1);
      q_rs1 = 5'd12; q_rs2 = 5'd0;
      #1;
      check("qhit_12", 32'(q_hit), 32'd1);
      q_rs1 = 5'd0;
      #1;
      check("qhit_zero", 32'(q_hit), 32'd0);
      q_rs2 = 5'd13;
      #1;
      check("qhit_rs2_13", 32'(q_hit), 32'd1);
      q_rs2 = 5'd14;
      #1;
      check("qhit_14_absent", 32'(q_hit), 32'd0);
      q_rs2 = 5'd0;
      a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_rd", 32'(rf_rd), 32'(10 + i));
         check("drain_wd", rf_wd, 32'(16'hB000 + i));
      end
      check("drain_count", 32'(fifo_count), 32'd0);

      // 5: A with rd 0 yields to B; B push of rd 0 is not stored
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
      tick();
      b_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hBAD;
      #1;
      check("a0_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      check("a0_b_rd", 32'(rf_rd), 32'd7);
      check("a0_b_wd", rf_wd, 32'h77);
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hF0;
      #1;
      check("b0_ready", 32'(b_ready), 32'd1);
      tick();
      b_valid = 1'b0;
      check("b0_count", 32'(fifo_count), 32'd0);
      check("b0_no_write", 32'(rf_we), 32'd0);

      // 6: starvation behaviour
      b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h2020;
      tick();
      b_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2222;
      #1;
      for (int k = 0; k < 8; k++) begin
         check("starve_a_ready", 32'(a_ready), 32'd1);
         tick();
      end
`ifdef RF_ARB_STARVE_GUARD_EN
      check("forced_a_ready", 32'(a_ready), 32'd0);
      check("forced_prev_rd", 32'(rf_rd), 32'd2);
      tick();
      check("forced_rd", 32'(rf_rd), 32'd20);
      check("forced_wd", rf_wd, 32'h2020);
      check("forced_count", 32'(fifo_count), 32'd0);
      check("forced_a_ready_back", 32'(a_ready), 32'd1);
      tick();
      check("retry_rd", 32'(rf_rd), 32'd2);
      a_valid = 1'b0;
`else
      check("noguard_a_ready", 32'(a_ready), 32'd1);
      check("noguard_count", 32'(fifo_count), 32'd1);
      check("noguard_rd", 32'(rf_rd), 32'd2);
      a_valid = 1'b0;
      tick();
      check("noguard_drain_rd", 32'(rf_rd), 32'd20);
`endif
      tick();

      // Mid-operation reset discards queued entries
      b_valid = 1'b1; b_rd = 5'd21; b_data = 32'h21;
      a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44;
      tick();
      b_rd = 5'd22;
      tick();
      check("pre_rst_count", 32'(fifo_count), 32'd2);
      rst = 1'b1; b_rd = 5'd3;
      tick();
      rst = 1'b0; b_valid = 1'b0; a_valid = 1'b0;
      #1;
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_we", 32'(rf_we), 32'd0);
      check("mid_rst_rd", 32'(rf_rd), 32'd0);
      check("mid_rst_b_ready", 32'(b_ready), 32'd1);
      tick();
      check("post_rst_idle", 32'(rf_we), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
